// File: rtl/fetch_seq.sv
// fetch_seq_pkg + fetch_seq
//
// Front-end fetch sequencer. It produces the FE1 side of the FE1->DE0
// instruction handshake. It walks sequential fetch PCs and issues them to
// the instruction memory port. In-order responses are buffered in a small
// queue and presented to decode. A branch mispredict (ex0) or a nuke (rb1)
// redirects fetch, flushes the queue and discards the responses to every
// request that is still in flight.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   decode_ready_de0  decode accepts instr_fe1 this cycle
//   valid_fe1         instr_fe1 holds a valid instruction
//   instr_fe1         {pc, instr} of the queue head
//   ic_req_valid      fetch request valid
//   ic_req_ready      memory accepts the request
//   ic_req_addr       fetch address (always fetch_pc, 4B aligned)
//   ic_rsp_valid      in-order response valid, never backpressured
//   ic_rsp_data       instruction word
//   br_mispred_ex0    mispredict redirect {valid, restore_pc}
//   nuke_rb1          nuke redirect {valid, restore_pc}; wins over ex0

package fetch_seq_pkg;
  typedef logic [31:0] t_paddr;

  typedef struct packed {
    t_paddr      pc;
    logic [31:0] instr;
  } t_instr_pkt;

  typedef struct packed {
    logic   valid;
    t_paddr restore_pc;
  } t_br_mispred_pkt;

  typedef struct packed {
    logic   valid;
    t_paddr restore_pc;
  } t_nuke_pkt;
endpackage

module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter int     DEPTH    = 4,
  parameter t_paddr RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            decode_ready_de0,
  output logic            valid_fe1,
  output t_instr_pkt      instr_fe1,
  output logic            ic_req_valid,
  input  logic            ic_req_ready,
  output t_paddr          ic_req_addr,
  input  logic            ic_rsp_valid,
  input  logic [31:0]     ic_rsp_data,
  input  t_br_mispred_pkt br_mispred_ex0,
  input  t_nuke_pkt       nuke_rb1
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_EXT = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, REDIRECT} t_state;

  t_state        state, state_next;
  t_paddr        fetch_pc;
  logic [CW-1:0] count, outst, drop_cnt, outst_after;
  logic [AW-1:0] q_rd, q_wr, tag_rd, tag_wr;
  t_instr_pkt    q_mem [DEPTH];
  t_paddr        tag_mem [DEPTH];
  logic          redir, redir_d;
  t_paddr        redir_target;
  logic          has_credit, req_fire, pop, enq;

  assign redir        = nuke_rb1.valid | br_mispred_ex0.valid;
  assign redir_target = nuke_rb1.valid ? nuke_rb1.restore_pc : br_mispred_ex0.restore_pc;

  // Outstanding requests plus queued entries never exceed DEPTH, so every
  // response that is kept is guaranteed a free queue slot.
  assign has_credit = ({1'b0, outst} + {1'b0, count}) < DEPTH_EXT;
  assign req_fire   = ic_req_valid & ic_req_ready;

  // A response landing in a redirect cycle belongs to the squashed stream.
  assign enq = ic_rsp_valid & (drop_cnt == '0) & ~redir;

  assign valid_fe1   = (count != '0) & ~redir_d;
  assign pop         = valid_fe1 & decode_ready_de0;
  assign instr_fe1   = q_mem[q_rd];
  assign ic_req_addr = fetch_pc;

  // No request fires in a redirect cycle, so outst_after is exactly the
  // set of requests still in flight once this cycle's response is retired.
  assign outst_after = outst + CW'(req_fire) - CW'(ic_rsp_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    ic_req_valid = 1'b0;
    case (state)
      IDLE: begin
        state_next = redir ? REDIRECT : FETCH;
      end
      FETCH: begin
        ic_req_valid = ~redir & has_credit;
        if (redir) begin
          state_next = REDIRECT;
        end
      end
      REDIRECT: begin
        state_next = redir ? REDIRECT : FETCH;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Fetch PC, request accounting and the squash counter. A redirect
  // recomputes drop_cnt from scratch, so back-to-back redirects never
  // count a request twice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      outst    <= '0;
      drop_cnt <= '0;
      redir_d  <= 1'b0;
      tag_wr   <= '0;
      tag_rd   <= '0;
    end else begin
      outst   <= outst_after;
      redir_d <= redir;
      if (redir) begin
        fetch_pc <= redir_target;
      end else if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (redir) begin
        drop_cnt <= outst_after;
      end else if (ic_rsp_valid && drop_cnt != '0) begin
        drop_cnt <= drop_cnt - 1'b1;
      end
      if (req_fire) begin
        tag_wr <= tag_wr + 1'b1;
      end
      if (ic_rsp_valid) begin
        tag_rd <= tag_rd + 1'b1;
      end
    end
  end

  // PC tags travel alongside the request stream and are consumed one per
  // response, including responses that end up discarded.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_mem[tag_wr] <= fetch_pc;
    end
  end

  // Instruction queue. A redirect empties it by snapping the read pointer
  // onto the write pointer; a pop in that same cycle has already delivered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_rd  <= '0;
      q_wr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_mem[i] <= '0;
      end
    end else if (redir) begin
      q_rd  <= q_wr;
      count <= '0;
    end else begin
      if (enq) begin
        q_mem[q_wr] <= '{pc: tag_mem[tag_rd], instr: ic_rsp_data};
        q_wr        <= q_wr + 1'b1;
      end
      if (pop) begin
        q_rd <= q_rd + 1'b1;
      end
      count <= count + CW'(enq) - CW'(pop);
    end
  end

  a_rsp_without_req: assert property (@(posedge clk) disable iff (reset)
    !(ic_rsp_valid && outst == '0));
  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    count <= CW'(DEPTH));
  a_addr_aligned: assert property (@(posedge clk) disable iff (reset)
    ic_req_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq
//
// Bench for fetch_seq. A memory responder returns in-order responses with a
// configurable random latency. Each response that belongs to the current
// fetch stream pushes its expected {pc, instr} onto a scoreboard queue. The
// monitor pops that queue on every decode handshake. A redirect issued by
// the stimulus starts a new stream epoch and flushes the scoreboard.
module tb_fetch_seq;
  import fetch_seq_pkg::*;

  localparam int     DEPTH    = 4;
  localparam t_paddr RESET_PC = 32'h0000_0100;

  logic            clk = 1'b0;
  logic            reset;
  logic            decode_ready_de0;
  logic            valid_fe1;
  t_instr_pkt      instr_fe1;
  logic            ic_req_valid;
  logic            ic_req_ready;
  t_paddr          ic_req_addr;
  logic            ic_rsp_valid;
  logic [31:0]     ic_rsp_data;
  t_br_mispred_pkt br_mispred_ex0;
  t_nuke_pkt       nuke_rb1;

  fetch_seq #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .reset            (reset),
    .decode_ready_de0 (decode_ready_de0),
    .valid_fe1        (valid_fe1),
    .instr_fe1        (instr_fe1),
    .ic_req_valid     (ic_req_valid),
    .ic_req_ready     (ic_req_ready),
    .ic_req_addr      (ic_req_addr),
    .ic_rsp_valid     (ic_rsp_valid),
    .ic_rsp_data      (ic_rsp_data),
    .br_mispred_ex0   (br_mispred_ex0),
    .nuke_rb1         (nuke_rb1)
  );

  always #5 clk = ~clk;

  typedef struct {
    t_paddr addr;
    int     due;
    int     epoch;
  } t_pend;

  typedef struct {
    t_paddr      pc;
    logic [31:0] instr;
  } t_exp;

  t_pend  pend[$];
  t_exp   exp_q[$];
  t_paddr redir_q[$];

  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  int     epoch = 0;
  int     last_due = 0;
  int     acc_cnt = 0;
  int     dlv_cnt = 0;
  int     lat_min = 1;
  int     lat_max = 1;
  t_paddr exp_req_addr = RESET_PC;
  logic   prev_stall = 1'b0;
  t_paddr prev_addr = '0;

  function automatic logic [31:0] mem_word(input t_paddr a);
    return (a ^ 32'hA5A5_0F0F) * 32'h9E37_79B1;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder: presents the oldest pending request once its latency
  // has elapsed; responses for the live stream feed the scoreboard.
  always @(posedge clk) begin
    t_pend p;
    t_exp  e;
    cyc++;
    #1;
    ic_rsp_valid = 1'b0;
    ic_rsp_data  = '0;
    if (!reset && pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      ic_rsp_valid = 1'b1;
      ic_rsp_data  = mem_word(p.addr);
      if (p.epoch == epoch) begin
        e.pc    = p.addr;
        e.instr = mem_word(p.addr);
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: request-side checks, scoreboard compare on each delivery, then
  // any redirect issued this cycle opens a new epoch.
  always @(negedge clk) begin
    t_pend p;
    t_exp  e;
    int    lat;
    if (!reset) begin
      if (prev_stall) begin
        check_output("req_addr_hold", 64'(ic_req_addr), 64'(prev_addr));
      end
      prev_stall = ic_req_valid & ~ic_req_ready;
      prev_addr  = ic_req_addr;
      if (ic_req_valid) begin
        check_output("req_addr_align", 64'(ic_req_addr[1:0]), 64'(0));
      end
      if (ic_req_valid && ic_req_ready) begin
        check_output("req_credit", 64'(pend.size() + exp_q.size() < DEPTH), 64'(1));
        check_output("req_addr", 64'(ic_req_addr), 64'(exp_req_addr));
        exp_req_addr = exp_req_addr + 32'd4;
        lat     = $urandom_range(lat_max, lat_min);
        p.addr  = ic_req_addr;
        p.due   = cyc + lat;
        if (p.due <= last_due) p.due = last_due + 1;
        last_due = p.due;
        p.epoch = epoch;
        pend.push_back(p);
        acc_cnt++;
      end
      if (valid_fe1 && decode_ready_de0) begin
        dlv_cnt++;
        check_output("dlv_pending", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_output("dlv_pc", 64'(instr_fe1.pc), 64'(e.pc));
          check_output("dlv_instr", 64'(instr_fe1.instr), 64'(e.instr));
        end
      end
      if (redir_q.size() > 0) begin
        exp_req_addr = redir_q.pop_front();
        exp_q.delete();
        epoch++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input logic dr, input logic rr, input int lmin, input int lmax);
    decode_ready_de0 = dr;
    ic_req_ready     = rr;
    lat_min          = lmin;
    lat_max          = lmax;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    br_mispred_ex0 = '0;
    nuke_rb1       = '0;
    ic_rsp_valid   = 1'b0;
    ic_rsp_data    = '0;
    pend.delete();
    exp_q.delete();
    redir_q.delete();
    epoch++;
    exp_req_addr = RESET_PC;
    last_due     = 0;
    prev_stall   = 1'b0;
    #1;
    check_output("rst_valid_fe1", 64'(valid_fe1), 64'(0));
    check_output("rst_req_valid", 64'(ic_req_valid), 64'(0));
    check_output("rst_req_addr", 64'(ic_req_addr), 64'(RESET_PC));
    check_output("rst_instr_fe1", 64'(instr_fe1), 64'(0));
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic redirect(input logic nv, input t_paddr nt, input logic bv, input t_paddr bt);
    nuke_rb1.valid           = nv;
    nuke_rb1.restore_pc      = nt;
    br_mispred_ex0.valid     = bv;
    br_mispred_ex0.restore_pc = bt;
    redir_q.push_back(nv ? nt : bt);
    step();
    nuke_rb1       = '0;
    br_mispred_ex0 = '0;
  endtask

  task automatic wait_delivery(output logic ok, output t_paddr pc);
    ok = 1'b0;
    pc = '0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      if (valid_fe1) begin
        ok = 1'b1;
        pc = instr_fe1.pc;
      end
      step();
    end
  endtask

  task automatic wait_accepts(input int need);
    int a0 = acc_cnt;
    for (int n = 0; n < 30 && acc_cnt - a0 < need; n++) step();
    check_output("inflight_reached", 64'(acc_cnt - a0 >= need), 64'(1));
  endtask

  initial begin
    int         first;
    int         d0;
    int         a0;
    logic       ok;
    t_paddr     pc;
    logic [1:0] sel;
    t_paddr     tgt_n;
    t_paddr     tgt_b;

    reset            = 1'b1;
    decode_ready_de0 = 1'b0;
    ic_req_ready     = 1'b0;
    ic_rsp_valid     = 1'b0;
    ic_rsp_data      = '0;
    br_mispred_ex0   = '0;
    nuke_rb1         = '0;

    // Latency-1 streaming from reset.
    apply_stimulus(1'b1, 1'b1, 1, 1);
    do_reset();
    first = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (valid_fe1 && first == 0) first = n;
      step();
    end
    check_output("first_valid_cycle", 64'(first), 64'(4));
    d0 = dlv_cnt;
    repeat (10) step();
    check_output("one_per_cycle", 64'(dlv_cnt - d0), 64'(10));

    // Decode stalled: the credit cap stops fetching after DEPTH requests.
    apply_stimulus(1'b0, 1'b1, 1, 1);
    do_reset();
    a0 = acc_cnt;
    repeat (10) step();
    @(negedge clk);
    check_output("full_req_valid", 64'(ic_req_valid), 64'(0));
    step();
    check_output("full_accepts", 64'(acc_cnt - a0), 64'(DEPTH));
    apply_stimulus(1'b1, 1'b1, 1, 1);
    d0 = dlv_cnt;
    repeat (4) step();
    check_output("drain_back_to_back", 64'(dlv_cnt - d0), 64'(DEPTH));
    repeat (6) step();

    // Mispredict with three requests in flight.
    apply_stimulus(1'b1, 1'b1, 3, 3);
    do_reset();
    wait_accepts(3);
    redirect(1'b0, '0, 1'b1, 32'h200);
    wait_delivery(ok, pc);
    check_output("br_wait", 64'(ok), 64'(1));
    check_output("br_first_pc", 64'(pc), 64'(32'h200));
    repeat (5) step();

    // Nuke and mispredict together: the nuke target is taken.
    apply_stimulus(1'b1, 1'b1, 2, 2);
    wait_accepts(2);
    redirect(1'b1, 32'h300, 1'b1, 32'h200);
    wait_delivery(ok, pc);
    check_output("nuke_wait", 64'(ok), 64'(1));
    check_output("nuke_first_pc", 64'(pc), 64'(32'h300));
    repeat (5) step();

    // Second redirect two cycles after the first.
    wait_accepts(2);
    redirect(1'b0, '0, 1'b1, 32'h200);
    step();
    redirect(1'b0, '0, 1'b1, 32'h400);
    wait_delivery(ok, pc);
    check_output("double_wait", 64'(ok), 64'(1));
    check_output("double_first_pc", 64'(pc), 64'(32'h400));
    ic_req_ready = 1'b0;
    for (int n = 0; n < 40 && pend.size() > 0; n++) step();
    check_output("double_drained", 64'(pend.size()), 64'(0));
    ic_req_ready = 1'b1;
    repeat (5) step();

    // Reset in the middle of a stalled, partly filled stream.
    apply_stimulus(1'b0, 1'b1, 3, 3);
    repeat (8) step();
    apply_stimulus(1'b1, 1'b1, 1, 1);
    do_reset();
    wait_delivery(ok, pc);
    check_output("rst_mid_wait", 64'(ok), 64'(1));
    check_output("rst_mid_first_pc", 64'(pc), 64'(RESET_PC));

    // Randomized traffic with random redirects.
    apply_stimulus(1'b1, 1'b1, 1, 4);
    repeat (5) step();
    for (int n = 0; n < 3000; n++) begin
      decode_ready_de0 = ($urandom_range(0, 3) != 0);
      ic_req_ready     = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) begin
        sel   = 2'($urandom_range(1, 3));
        tgt_n = $urandom() & 32'hFFFF_FFFC;
        tgt_b = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
        nuke_rb1.valid            = sel[0];
        nuke_rb1.restore_pc       = tgt_n;
        br_mispred_ex0.valid      = sel[1];
        br_mispred_ex0.restore_pc = tgt_b;
        redir_q.push_back(sel[0] ? tgt_n : tgt_b);
      end else begin
        nuke_rb1       = '0;
        br_mispred_ex0 = '0;
      end
      step();
    end
    nuke_rb1       = '0;
    br_mispred_ex0 = '0;
    apply_stimulus(1'b1, 1'b0, 1, 1);
    repeat (60) step();
    check_output("end_pend_empty", 64'(pend.size()), 64'(0));
    check_output("end_queue_empty", 64'(exp_q.size()), 64'(0));
    check_output("end_valid_low", 64'(valid_fe1), 64'(0));
    check_output("progress", 64'(dlv_cnt > 500), 64'(1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Front-end fetch sequencer: the producer side of the FE1→DE0 instruction handshake.
- Generates sequential fetch PCs, issues requests to the instruction memory port and buffers in-order responses in a small queue.
- Presents instr_fe1/valid_fe1 to decode under decode_ready_de0 backpressure.
- Redirects on branch mispredict (ex0) or nuke (rb1), squashing queued and in-flight fetches.

Parameters:
- DEPTH, 4, fetch queue entries; also the cap on outstanding requests plus queued entries (power of 2, ≥2).
- RESET_PC, 0, first fetch address after reset (t_paddr).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- decode_ready_de0  in  1  decode accepts the FE1 instruction this cycle
- valid_fe1  out  1  instr_fe1 is valid
- instr_fe1  out  t_instr_pkt  delivered instruction: .pc, .instr (32b)
- ic_req_valid  out  1  fetch request valid
- ic_req_ready  in  1  memory accepts request
- ic_req_addr  out  t_paddr  fetch address, 4B aligned
- ic_rsp_valid  in  1  response valid; responses return in request order, ≥1 cycle after acceptance, never backpressured
- ic_rsp_data  in  32  instruction word
- br_mispred_ex0  in  t_br_mispred_pkt  uses .valid, .restore_pc
- nuke_rb1  in  t_nuke_pkt  uses .valid, .restore_pc

Behaviour:
- Reset (async assert): state=IDLE; fetch_pc=RESET_PC; queue empty; outst=0; drop_cnt=0.
  - Reset outputs: valid_fe1=0, ic_req_valid=0, ic_req_addr=RESET_PC, instr_fe1=0.
- Redirect qualifier: redir = nuke_rb1.valid | br_mispred_ex0.valid.
  - Target = nuke_rb1.restore_pc if nuke_rb1.valid, else br_mispred_ex0.restore_pc (nuke wins on a simultaneous event).
- FSM (3 states):
  - IDLE → FETCH: the first cycle after reset is deasserted; no request is issued in IDLE.
  - FETCH: ic_req_valid = ~redir & (outst + count < DEPTH). On ic_req_valid & ic_req_ready: outst++ and fetch_pc += 4 (wraps modulo t_paddr width). On redir → REDIRECT.
  - REDIRECT: exactly one bubble cycle, ic_req_valid=0, then → FETCH. A redir arriving in REDIRECT reloads the target and stays one more cycle.
- ic_req_addr = fetch_pc at all times; it is held stable while ic_req_valid & ~ic_req_ready.
- Response handling:
  - On ic_rsp_valid: outst--.
  - If drop_cnt>0: the response is discarded and drop_cnt--.
  - Otherwise it is enqueued as {pc = pc tag tracked per outstanding request, instr = ic_rsp_data}.
  - Keep a per-request PC FIFO of depth DEPTH alongside the request stream.
- Redirect cycle actions:
  - Queue flushed (count=0).
  - fetch_pc ← target.
  - drop_cnt ← outst_after_this_cycle, i.e. all still-outstanding requests. This excludes a response arriving this cycle, which is itself dropped.
  - A second redirect while draining recomputes drop_cnt the same way; no double counting.
- Decode interface:
  - valid_fe1 = (count != 0) & ~redir_d, where redir_d is the redirect registered one cycle.
  - instr_fe1 = queue head.
  - Pop on valid_fe1 & decode_ready_de0.
  - Pop and redir in the same cycle: the pop counts as delivered; the flush then clears the remainder.
- Latency: request accepted in cycle N → response at N+k (k≥1) → valid_fe1 at N+k+1 (no response→output bypass).
- Queue full: count+outst==DEPTH blocks requests. Because of this cap, responses can never overflow the queue.
- Enqueue and pop in the same cycle on a full queue are legal. The credit freed by the pop is visible next cycle.
- Delivered PC stream:
  - Strictly sequential +4 between redirects.
  - The first instruction after a redirect has pc == target.
  - No squashed instruction is ever presented.
- Assertions (ASSERT): ic_rsp_valid with outst==0; count>DEPTH; ic_req_addr[1:0]!=0.

Test Plan:
- Reset, RESET_PC=0x100, ic_req_ready=1, rsp latency 1, decode_ready_de0=1 → first valid_fe1 with pc=0x100 in cycle 4 after reset release; then pc 0x104, 0x108… one per cycle.
- decode_ready_de0=0 for 10 cycles with DEPTH=4 → exactly 4 requests accepted, ic_req_valid then 0; release → 0x100..0x10C delivered back-to-back, fetching resumes at 0x110.
- Latency 3, br_mispred_ex0.valid with restore_pc=0x200 while 3 requests are outstanding → those 3 responses are dropped; next delivered pc=0x200, with no 0x1xx pc presented after the redirect.
- nuke_rb1 (restore_pc=0x300) and br_mispred_ex0 (0x200) asserted in the same cycle → next delivered pc=0x300.
- Redirect to 0x200, then a second redirect to 0x400 two cycles later with requests in flight → only pc=0x400 onward is delivered; outst returns to 0 with no assertion fired.
- Reset asserted mid-stream with a full queue and outstanding requests → outputs go to reset values immediately; after release, pc=RESET_PC is delivered first.
